// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types and sizing for the counter sweep controller.
package counter_sweep_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int LAPS_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/updn_counter_core.sv
// Loadable up/down counter; load wins over count enable.
module updn_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up_down ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: counts lo..hi..lo once (mode 0) or ping-pongs (mode 1).
import counter_sweep_ctrl_pkg::*;

module counter_sweep_ctrl #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic              mode,
  output logic [WIDTH-1:0]  count,
  output logic              up_down,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LAPS_W-1:0] laps
);

  state_t           state, state_n;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             mode_q;
  logic             dir_n;
  logic             load, en, step_up;
  logic             latch, laps_inc, err_n;

  updn_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .en      (en),
    .up_down (step_up),
    .d       (lo),
    .q       (count)
  );

  assign busy = (state == ST_UP) || (state == ST_DOWN);
  assign done = (state == ST_DONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    dir_n    = up_down;
    load     = 1'b0;
    en       = 1'b0;
    step_up  = 1'b1;
    latch    = 1'b0;
    laps_inc = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            latch   = 1'b1;
            load    = 1'b1;
            dir_n   = 1'b1;
            state_n = ST_UP;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (count < hi_q) begin
          en = 1'b1;
        end else if (hi_q > lo_q) begin
          en      = 1'b1;
          step_up = 1'b0;
          dir_n   = 1'b0;
          state_n = ST_DOWN;
        end else if (mode_q) begin
          dir_n   = 1'b0;
          state_n = ST_DOWN;
        end else begin
          // Degenerate single sweep finishes after one busy cycle.
          state_n = ST_DONE;
        end
      end
      ST_DOWN: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (count > lo_q) begin
          en      = 1'b1;
          step_up = 1'b0;
        end else if (mode_q) begin
          laps_inc = 1'b1;
          dir_n    = 1'b1;
          en       = (hi_q > lo_q);
          state_n  = ST_UP;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      up_down <= 1'b1;
      err     <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 1'b0;
      laps    <= '0;
    end else begin
      state   <= state_n;
      up_down <= dir_n;
      err     <= err_n;
      if (latch) begin
        lo_q   <= lo;
        hi_q   <= hi;
        mode_q <= mode;
        laps   <= '0;
      end else if (laps_inc && (laps != '1)) begin
        laps <= laps + LAPS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench: vector table for a single sweep plus hand-written corner sequences.
module tb_counter_sweep_ctrl;

  logic       clk, reset, start, stop, mode;
  logic [3:0] lo, hi, count;
  logic       up_down, busy, done, err;
  logic [7:0] laps;

  int checks = 0;
  int errors = 0;

  counter_sweep_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .mode(mode), .count(count), .up_down(up_down), .busy(busy), .done(done),
    .err(err), .laps(laps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, mode;
    logic [3:0] lo, hi;
    logic [3:0] e_count;
    logic       e_ud, e_busy, e_done, e_err;
    logic [7:0] e_laps;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic [3:0] l, input logic [3:0] h,
                       input logic m);
    start = s; stop = p; lo = l; hi = h; mode = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic ud,
                           input logic b, input logic d, input logic e, input logic [7:0] lp);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".up_down"}, 32'(up_down), 32'(ud));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".laps"}, 32'(laps), 32'(lp));
  endtask

  initial begin
    int busy_cycles;
    int done_seen;

    // start, stop, mode, lo, hi | count, up_down, busy, done, err, laps
    vecs[0]  = '{1, 0, 0, 4'd2, 4'd5, 4'd2, 1, 1, 0, 0, 8'd0};
    vecs[1]  = '{1, 0, 1, 4'd0, 4'd1, 4'd3, 1, 1, 0, 0, 8'd0};  // start mid-sweep ignored
    vecs[2]  = '{0, 0, 1, 4'd9, 4'd3, 4'd4, 1, 1, 0, 0, 8'd0};  // limit changes ignored
    vecs[3]  = '{0, 0, 0, 4'd9, 4'd3, 4'd5, 1, 1, 0, 0, 8'd0};
    vecs[4]  = '{0, 0, 0, 4'd9, 4'd3, 4'd4, 0, 1, 0, 0, 8'd0};
    vecs[5]  = '{0, 0, 0, 4'd9, 4'd3, 4'd3, 0, 1, 0, 0, 8'd0};
    vecs[6]  = '{0, 0, 0, 4'd9, 4'd3, 4'd2, 0, 1, 0, 0, 8'd0};
    vecs[7]  = '{0, 0, 0, 4'd2, 4'd5, 4'd2, 0, 0, 1, 0, 8'd0};
    vecs[8]  = '{0, 0, 0, 4'd2, 4'd5, 4'd2, 0, 0, 0, 0, 8'd0};
    vecs[9]  = '{1, 0, 0, 4'd9, 4'd4, 4'd2, 0, 0, 0, 1, 8'd0};  // rejected start
    vecs[10] = '{0, 0, 0, 4'd9, 4'd4, 4'd2, 0, 0, 0, 0, 8'd0};

    reset = 1'b0;
    drive(0, 0, 4'd0, 4'd0, 0);
    #12;
    check_all("reset", 4'd0, 1, 0, 0, 0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].lo, vecs[i].hi, vecs[i].mode);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ud, vecs[i].e_busy,
                vecs[i].e_done, vecs[i].e_err, vecs[i].e_laps);
    end

    // Mode 1 ping-pong 0..3: six cycles per round trip, third lap lands on edge 19.
    drive(1, 0, 4'd0, 4'd3, 1);
    step();
    drive(0, 0, 4'd0, 4'd3, 1);
    done_seen = 0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (done) done_seen++;
      check($sformatf("pp.range%0d", i), 32'(count <= 4'd3), 32'd1);
    end
    check("pp.done_never", 32'(done_seen), 32'd0);
    check_all("pp.lap3", 4'd1, 1, 1, 0, 0, 8'd3);
    drive(0, 1, 4'd0, 4'd3, 1);
    step();
    check_all("pp.stop", 4'd1, 1, 0, 0, 0, 8'd3);
    drive(0, 0, 4'd0, 4'd3, 0);
    step();

    // Degenerate single sweep: one busy cycle then done.
    drive(1, 0, 4'd7, 4'd7, 0);
    step();
    drive(0, 0, 4'd7, 4'd7, 0);
    check_all("deg0.up", 4'd7, 1, 1, 0, 0, 8'd0);
    step();
    check_all("deg0.done", 4'd7, 1, 0, 1, 0, 8'd0);
    step();
    check_all("deg0.idle", 4'd7, 1, 0, 0, 0, 8'd0);

    // Degenerate ping-pong: laps advances every two cycles.
    drive(1, 0, 4'd7, 4'd7, 1);
    step();
    drive(0, 0, 4'd7, 4'd7, 1);
    step();
    check_all("deg1.down", 4'd7, 0, 1, 0, 0, 8'd0);
    step();
    check_all("deg1.lap1", 4'd7, 1, 1, 0, 0, 8'd1);
    step();
    step();
    check_all("deg1.lap2", 4'd7, 1, 1, 0, 0, 8'd2);
    drive(0, 1, 4'd7, 4'd7, 1);
    step();
    check("deg1.stop_busy", 32'(busy), 32'd0);
    drive(0, 0, 4'd7, 4'd7, 0);

    // Stop coinciding with count==hi must go to IDLE, not DOWN.
    drive(1, 0, 4'd2, 4'd5, 0);
    step();
    drive(0, 0, 4'd2, 4'd5, 0);
    step(); step(); step();
    check("stophi.at_hi", 32'(count), 32'd5);
    drive(0, 1, 4'd2, 4'd5, 0);
    step();
    check_all("stophi.idle", 4'd5, 1, 0, 0, 0, 8'd0);
    drive(0, 0, 4'd2, 4'd5, 0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) done_seen++;
    end
    check("stophi.quiet", 32'(done_seen), 32'd0);

    // Async reset between edges at count==4, then start on first edge after release.
    drive(1, 0, 4'd2, 4'd6, 0);
    step();
    drive(0, 0, 4'd2, 4'd6, 0);
    step(); step();
    check("arst.pre", 32'(count), 32'd4);
    #3;
    reset = 1'b0;
    #1;
    check_all("arst.now", 4'd0, 1, 0, 0, 0, 8'd0);
    drive(1, 0, 4'd1, 4'd2, 0);
    #1;
    reset = 1'b1;
    step();
    drive(0, 0, 4'd1, 4'd2, 0);
    check_all("arst.first_start", 4'd1, 1, 1, 0, 0, 8'd0);
    busy_cycles = 1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy) busy_cycles++;
      if (done) done_seen++;
    end
    check("arst.busy_len", 32'(busy_cycles), 32'd3);
    check("arst.done_once", 32'(done_seen), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of counter value and limits.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  begin a sweep; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort the active sweep.
REQ-006 Port: lo  input  WIDTH  lower sweep limit, unsigned.
REQ-007 Port: hi  input  WIDTH  upper sweep limit, unsigned.
REQ-008 Port: mode  input  1  0 = single up-then-down sweep; 1 = continuous ping-pong.
REQ-009 Port: count  output  WIDTH  current counter value.
REQ-010 Port: up_down  output  1  current direction: 1 = up, 0 = down.
REQ-011 Port: busy  output  1  high in UP or DOWN.
REQ-012 Port: done  output  1  one-cycle pulse when a mode-0 sweep completes.
REQ-013 Port: err  output  1  one-cycle pulse when start is rejected.
REQ-014 Port: laps  output  8  completed round trips in mode 1; saturates at 255.

Function
REQ-015 States: IDLE, UP, DOWN, DONE; the FSM shall make one transition per clock edge at most.
REQ-016 IDLE with start=1 and lo<=hi shall latch lo, hi and mode, load count=lo, clear laps, and enter UP on the same edge.
REQ-017 IDLE with start=1 and lo>hi shall pulse err for one cycle, stay in IDLE and leave count unchanged.
REQ-018 UP with count<hi shall increment count by 1 per cycle.
REQ-019 UP with count==hi shall enter DOWN and decrement count on the same edge if hi>lo, or hold count if hi==lo.
REQ-020 DOWN with count>lo shall decrement count by 1 per cycle.
REQ-021 DOWN with count==lo in mode 0 shall enter DONE and hold count.
REQ-022 DOWN with count==lo in mode 1 shall enter UP, increment laps (saturating), and increment count if hi>lo or hold it if hi==lo.
REQ-023 DONE shall assert done for exactly one cycle, then return to IDLE.
REQ-024 stop=1 in UP or DOWN shall force IDLE on the next edge, hold count, and suppress done.
REQ-025 stop has priority over boundary transitions.
REQ-026 start in any state other than IDLE shall be ignored.
REQ-027 Latched limits and mode shall not change while busy; input changes during a sweep have no effect.
REQ-028 count shall never leave the range [latched lo, latched hi] during a sweep, and shall never wrap.
REQ-029 up_down shall be 1 in UP, 0 in DOWN, and keep its last value in IDLE and DONE.
REQ-030 Mode-0 latency: start edge to done pulse equals 2*(hi-lo)+1 cycles; busy is high for the same number of cycles.

Reset
REQ-031 reset low shall immediately force IDLE, count=0, up_down=1, busy=0, done=0, err=0, laps=0, and clear the latched limits and mode.
REQ-032 Reset asserted mid-sweep shall abort the sweep with no done pulse.
REQ-033 The first start shall be accepted on the first rising edge after reset deasserts.

Structure
REQ-034 A shared package shall hold the state enumeration, the WIDTH default and the laps width (8).
REQ-035 The counter datapath shall be a sub-module updn_counter_core with ports clk, reset, load, en, up_down, d and q; the controller drives load, en and up_down.

Verification
REQ-036 Mode-0 sweep: lo=2, hi=5, start pulse -> count 2,3,4,5,4,3,2 on successive cycles; done pulses once on cycle 7; busy high for 7 cycles.
REQ-037 Mode-1 ping-pong: lo=0, hi=3, run 3 round trips -> laps=3, count stays within 0..3, done never asserts; then stop -> IDLE next cycle with count held.
REQ-038 Rejected start: lo=9, hi=4, start -> err is a 1-cycle pulse, busy stays 0, count unchanged.
REQ-039 Degenerate limits: lo=hi=7, mode 0 -> count holds 7, done pulses after 1 cycle of busy; mode 1 -> count holds 7 and laps increments every 2 cycles.
REQ-040 Async reset mid-sweep: assert reset between clock edges at count=4 -> outputs take reset values immediately, with no done pulse.
REQ-041 Edge cases: start during busy is ignored; lo/hi changes mid-sweep have no effect; stop coinciding with count==hi -> IDLE, not DOWN.
